// File: rtl/injection_arbiter_if.sv
// Bundle of source-side and router-side signals for injection_arbiter.
// The slave modport is the arbiter; the master modport is the environment
// (packet sources plus the router's credit return path).
interface injection_arbiter_if #(
    parameter int FLIT_WIDTH   = 32,
    parameter int PACKET_FLITS = 5,
    parameter int REQUESTERS   = 4
);
    logic [REQUESTERS-1:0]                         request_din;
    logic [REQUESTERS*PACKET_FLITS*FLIT_WIDTH-1:0] packet_din;
    logic [REQUESTERS-1:0]                         grant_dout;
    logic [FLIT_WIDTH-1:0]                         flit_dout;
    logic                                          done_strobe_dout;
    logic                                          credit_in_din;
    logic                                          busy_dout;

    modport master (
        output request_din, packet_din, credit_in_din,
        input  grant_dout, flit_dout, done_strobe_dout, busy_dout
    );

    modport slave (
        input  request_din, packet_din, credit_in_din,
        output grant_dout, flit_dout, done_strobe_dout, busy_dout
    );
endinterface

// File: rtl/injection_arbiter.sv
// injection_arbiter: round-robin arbitration among packet sources, capture of
// the winning packet, and flit-by-flit serialization onto one router input
// channel under credit-based flow control.
// Optional feature macro: NULL_PACKET_FILTER_EN -- packets whose head flit has
// ID_HEAD (MSB) clear are granted but dropped, and counted on
// dropped_count_dout.
module injection_arbiter #(
    parameter int FLIT_WIDTH   = 32,
    parameter int PACKET_FLITS = 5,
    parameter int REQUESTERS   = 4,
    parameter int CREDITS      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    injection_arbiter_if.slave   bus
`ifdef NULL_PACKET_FILTER_EN
    ,
    output logic [15:0]          dropped_count_dout
`endif
);
    localparam int PKT_W = PACKET_FLITS * FLIT_WIDTH;
    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int CW    = IDX_W + 1;
    localparam int FI_W  = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;
    localparam int CNT_W = $clog2(CREDITS + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [REQUESTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [FI_W-1:0]       flit_idx_q, flit_idx_d;
    logic [CNT_W-1:0]      credit_count_q, credit_count_d;
    logic [FLIT_WIDTH-1:0] flit_q, flit_d;
    logic                  done_strobe_q, done_strobe_d;
    logic                  busy_q, busy_d;
    logic [PKT_W-1:0]      packet_q, packet_d;

    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [CW-1:0]         cand;
    logic [PKT_W-1:0]      win_packet;
    logic [FLIT_WIDTH-1:0] cur_flit;
    logic                  issue;
    logic                  drop_now;

    // Round-robin search from last_grant+1 with wrap, then select the winner's packet.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        win_packet = '0;
        for (int i = 1; i <= REQUESTERS; i++) begin
            cand = {1'b0, last_grant_q} + CW'(i);
            if (cand >= CW'(REQUESTERS)) begin
                cand = cand - CW'(REQUESTERS);
            end
            if (!win_found && bus.request_din[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
        for (int r = 0; r < REQUESTERS; r++) begin
            if (win_idx == IDX_W'(r)) begin
                win_packet = bus.packet_din[r*PKT_W +: PKT_W];
            end
        end
    end

    // Pick the current flit out of the held packet; flit 0 sits in the MSBs.
    always_comb begin
        cur_flit = '0;
        for (int f = 0; f < PACKET_FLITS; f++) begin
            if (flit_idx_q == FI_W'(f)) begin
                cur_flit = packet_q[(PACKET_FLITS-1-f)*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    // FSM next state, output registers and credit accounting.
    always_comb begin
        state_d        = state_q;
        grant_d        = '0;
        last_grant_d   = last_grant_q;
        flit_idx_d     = flit_idx_q;
        flit_d         = flit_q;
        done_strobe_d  = 1'b0;
        busy_d         = busy_q;
        packet_d       = packet_q;
        issue          = 1'b0;
        credit_count_d = credit_count_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (win_found) begin
                    grant_d[win_idx] = 1'b1;
                    last_grant_d     = win_idx;
                    packet_d         = win_packet;
                    flit_idx_d       = '0;
                    busy_d           = 1'b1;
                    state_d          = SEND;
                end
            end
            SEND: begin
                if (drop_now) begin
                    // Null packet: nothing goes on the wire, no credit used.
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (credit_count_q != '0) begin
                    issue         = 1'b1;
                    flit_d        = cur_flit;
                    done_strobe_d = 1'b1;
                    flit_idx_d    = flit_idx_q + 1'b1;
                    if (flit_idx_q == FI_W'(PACKET_FLITS - 1)) begin
                        flit_idx_d = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Issue and return together cancel; a return at full count is dropped.
        if (issue && !bus.credit_in_din) begin
            credit_count_d = credit_count_q - 1'b1;
        end else if (!issue && bus.credit_in_din &&
                     credit_count_q != CNT_W'(CREDITS)) begin
            credit_count_d = credit_count_q + 1'b1;
        end
    end

    // Control and output registers; reset also discards any packet in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            last_grant_q   <= IDX_W'(REQUESTERS - 1);
            flit_idx_q     <= '0;
            credit_count_q <= CNT_W'(CREDITS);
            flit_q         <= '0;
            done_strobe_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            flit_idx_q     <= flit_idx_d;
            credit_count_q <= credit_count_d;
            flit_q         <= flit_d;
            done_strobe_q  <= done_strobe_d;
            busy_q         <= busy_d;
        end
    end

    // Captured packet is pure data and is only consumed after a grant.
    always_ff @(posedge clk) begin
        packet_q <= packet_d;
    end

`ifdef NULL_PACKET_FILTER_EN
    logic [15:0] dropped_q, dropped_d;

    assign drop_now = ~packet_q[PKT_W-1];

    // Count null packets discarded right after their grant (wraps).
    always_comb begin
        dropped_d = dropped_q;
        if (state_q == SEND && drop_now) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    // Dropped-packet counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_q <= '0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign dropped_count_dout = dropped_q;
`else
    assign drop_now = 1'b0;
`endif

    assign bus.grant_dout       = grant_q;
    assign bus.flit_dout        = flit_q;
    assign bus.done_strobe_dout = done_strobe_q;
    assign bus.busy_dout        = busy_q;
endmodule

// File: tb/tb_injection_arbiter.sv
// Self-checking bench for injection_arbiter: expected grants and flits are
// queued as stimulus is applied and compared as the DUT produces them.
`timescale 1ns/1ps
module tb_injection_arbiter;
    localparam int FW = 32;
    localparam int PF = 5;
    localparam int RQ = 4;
    localparam int CR = 4;
    localparam int PW = FW * PF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;
    int   cp;

    logic [PW-1:0] pkt [RQ];
    logic [RQ-1:0] exp_grant_q [$];
    logic [FW-1:0] exp_flit_q [$];
    int            grant_cyc [$];
    int            strobe_cyc [$];

    injection_arbiter_if #(.FLIT_WIDTH(FW), .PACKET_FLITS(PF), .REQUESTERS(RQ)) bus ();

`ifdef NULL_PACKET_FILTER_EN
    logic [15:0] dropped;
`endif

    injection_arbiter #(
        .FLIT_WIDTH(FW), .PACKET_FLITS(PF), .REQUESTERS(RQ), .CREDITS(CR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef NULL_PACKET_FILTER_EN
        ,
        .dropped_count_dout(dropped)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] make_pkt(input int r);
        logic [PW-1:0] p;
        p = '0;
        p[PW-1 -: FW] = {8'h80, 8'(r), 16'hC0DE};
        for (int f = 1; f < PF; f++) begin
            p[(PF-1-f)*FW +: FW] = {8'(r), 8'(f), 16'hDA7A};
        end
        return p;
    endfunction

    task automatic load_packets();
        for (int r = 0; r < RQ; r++) begin
            bus.packet_din[r*PW +: PW] = pkt[r];
        end
    endtask

    task automatic push_pkt(input int r);
        exp_grant_q.push_back(RQ'(1) << r);
        for (int f = 0; f < PF; f++) begin
            exp_flit_q.push_back(pkt[r][(PF-1-f)*FW +: FW]);
        end
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k;
        k = 0;
        while (strobe_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (strobe_cyc.size() < n) check_eq("strobe_timeout", 64'(strobe_cyc.size()), 64'(n));
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k;
        k = 0;
        while (grant_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (grant_cyc.size() < n) check_eq("grant_timeout", 64'(grant_cyc.size()), 64'(n));
    endtask

    task automatic do_reset();
        check_eq("leftover_flits", 64'(exp_flit_q.size()), 64'(0));
        check_eq("leftover_grants", 64'(exp_grant_q.size()), 64'(0));
        reset = 1'b1;
        bus.request_din = '0;
        bus.credit_in_din = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        strobe_cyc.delete();
        grant_cyc.delete();
    endtask

    // Output monitor: pops the scoreboard for every grant and every strobe.
    always @(negedge clk) begin
        if (bus.grant_dout != '0) begin
            grant_cyc.push_back(cyc);
            if (exp_grant_q.size() == 0) check_eq("grant_unexpected", 64'(bus.grant_dout), 64'(0));
            else check_eq("grant", 64'(bus.grant_dout), 64'(exp_grant_q.pop_front()));
        end
        if (bus.done_strobe_dout) begin
            strobe_cyc.push_back(cyc);
            if (exp_flit_q.size() == 0) check_eq("flit_unexpected", 64'(bus.flit_dout), 64'(0));
            else check_eq("flit", 64'(bus.flit_dout), 64'(exp_flit_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.request_din = '0;
        bus.credit_in_din = 1'b0;
        for (int r = 0; r < RQ; r++) pkt[r] = make_pkt(r);
        pkt[2] = {32'h8000_0A0B, 32'h782B_2020, 32'h7820_3D32, 32'h7920_3D31, 32'h4E54_5354};
        load_packets();

        // Reset state
        do_reset();
        check_eq("rst_grant", 64'(bus.grant_dout), 64'(0));
        check_eq("rst_flit", 64'(bus.flit_dout), 64'(0));
        check_eq("rst_strobe", 64'(bus.done_strobe_dout), 64'(0));
        check_eq("rst_busy", 64'(bus.busy_dout), 64'(0));
        check_eq("rst_credit", 64'(dut.credit_count_q), 64'(CR));

        // Single packet from source 2, fifth flit stalled for a credit
        push_pkt(2);
        t0 = cyc;
        bus.request_din[2] = 1'b1;
        tick();
        bus.request_din[2] = 1'b0;
        check_eq("t1_grant", 64'(bus.grant_dout), 64'(4'b0100));
        check_eq("t1_busy_grant", 64'(bus.busy_dout), 64'(1));
        tick();
        check_eq("t1_grant_pulse", 64'(bus.grant_dout), 64'(0));
        wait_strobes(4, 20);
        repeat (5) tick();
        check_eq("t1_stall_count", 64'(strobe_cyc.size()), 64'(4));
        check_eq("t1_credit_zero", 64'(dut.credit_count_q), 64'(0));
        check_eq("t1_busy_stall", 64'(bus.busy_dout), 64'(1));
        cp = cyc;
        bus.credit_in_din = 1'b1;
        tick();
        bus.credit_in_din = 1'b0;
        wait_strobes(5, 10);
        for (int i = 0; i < 4; i++) check_eq("t1_back_to_back", 64'(strobe_cyc[i]), 64'(t0 + 2 + i));
        check_eq("t1_fifth_after_return", 64'(strobe_cyc[4]), 64'(cp + 2));
        check_eq("t1_credit_end", 64'(dut.credit_count_q), 64'(0));
        check_eq("t1_busy_end", 64'(bus.busy_dout), 64'(0));

        // Round robin among sources 0, 1, 3 with a credit returned every cycle
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push_pkt(0);
            push_pkt(1);
            push_pkt(3);
        end
        bus.credit_in_din = 1'b1;
        bus.request_din = 4'b1011;
        wait_grants(6, 60);
        bus.request_din = '0;
        wait_strobes(30, 60);
        for (int i = 0; i < 5; i++) check_eq("t2_grant_spacing", 64'(grant_cyc[i+1] - grant_cyc[i]), 64'(6));
        check_eq("t2_credit_full", 64'(dut.credit_count_q), 64'(CR));
        bus.credit_in_din = 1'b0;

        // Return in the same cycle as an issue at count 1, then saturation
        do_reset();
        push_pkt(3);
        t0 = cyc;
        bus.request_din[3] = 1'b1;
        tick();
        bus.request_din[3] = 1'b0;
        repeat (3) tick();
        bus.credit_in_din = 1'b1;
        tick();
        bus.credit_in_din = 1'b0;
        check_eq("t3_issue_and_return", 64'(dut.credit_count_q), 64'(1));
        wait_strobes(5, 10);
        check_eq("t3_fifth_flit_time", 64'(strobe_cyc[4]), 64'(t0 + 6));
        check_eq("t3_credit_drained", 64'(dut.credit_count_q), 64'(0));
        bus.credit_in_din = 1'b1;
        repeat (4) tick();
        check_eq("t3_refill", 64'(dut.credit_count_q), 64'(CR));
        tick();
        check_eq("t3_saturate", 64'(dut.credit_count_q), 64'(CR));
        bus.credit_in_din = 1'b0;

        // Reset during the cycle carrying the second flit
        do_reset();
        t0 = cyc;
        exp_grant_q.push_back(4'b0001);
        exp_flit_q.push_back(pkt[0][PW-1 -: FW]);
        exp_flit_q.push_back(pkt[0][PW-1-FW -: FW]);
        bus.request_din[0] = 1'b1;
        tick();
        bus.request_din[0] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("t4_grant", 64'(bus.grant_dout), 64'(0));
        check_eq("t4_flit", 64'(bus.flit_dout), 64'(0));
        check_eq("t4_strobe", 64'(bus.done_strobe_dout), 64'(0));
        check_eq("t4_busy", 64'(bus.busy_dout), 64'(0));
        check_eq("t4_state_idle", 64'(dut.state_q), 64'(0));
        check_eq("t4_credit_reload", 64'(dut.credit_count_q), 64'(CR));
        reset = 1'b0;
        repeat (10) tick();
        check_eq("t4_no_third_flit", 64'(strobe_cyc.size()), 64'(2));

`ifdef NULL_PACKET_FILTER_EN
        // Null packet from source 1 followed by a real packet from source 2
        do_reset();
        pkt[1][PW-1] = 1'b0;
        load_packets();
        exp_grant_q.push_back(4'b0010);
        push_pkt(2);
        bus.credit_in_din = 1'b1;
        bus.request_din[1] = 1'b1;
        tick();
        bus.request_din[1] = 1'b0;
        bus.request_din[2] = 1'b1;
        check_eq("t5_dropped_before", 64'(dropped), 64'(0));
        tick();
        check_eq("t5_dropped_after", 64'(dropped), 64'(1));
        check_eq("t5_credit_kept", 64'(dut.credit_count_q), 64'(CR));
        tick();
        check_eq("t5_no_null_strobe", 64'(strobe_cyc.size()), 64'(0));
        bus.request_din[2] = 1'b0;
        wait_strobes(5, 20);
        check_eq("t5_next_grant_gap", 64'(grant_cyc[1] - grant_cyc[0]), 64'(2));
        bus.credit_in_din = 1'b0;
        pkt[1] = make_pkt(1);
        load_packets();
`endif

        tick();
        check_eq("final_flits_drained", 64'(exp_flit_q.size()), 64'(0));
        check_eq("final_grants_drained", 64'(exp_grant_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
